// File: rtl/maze_render_pkg.sv
// Shared constants and types for the maze scene renderer: TFT opcodes,
// controller states, pixel classes and default palette.
package maze_render_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [23:0] DEF_WALL_COLOR = 24'h3A7BD5;
    localparam logic [23:0] DEF_FOOD_COLOR = 24'hF0C020;
    localparam logic [23:0] DEF_BG_COLOR   = 24'h000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_CASET_ARG,
        ST_PASET,
        ST_PASET_ARG,
        ST_RAMWR,
        ST_PIXELS,
        ST_DONE
    } render_state_e;

    typedef enum logic [1:0] {
        PIX_BG   = 2'd0,
        PIX_WALL = 2'd1,
        PIX_FOOD = 2'd2
    } pix_class_e;

endpackage

// File: rtl/tile_pixel_classifier.sv
// Combinational wall/food/background classification of one pixel inside a tile.
module tile_pixel_classifier
    import maze_render_pkg::*;
#(
    parameter int TILE   = 32,
    parameter int WALL_W = 2,
    parameter int FOOD_W = 8
) (
    input  logic [$clog2(TILE)-1:0] px,
    input  logic [$clog2(TILE)-1:0] py,
    input  logic                    wall_left,
    input  logic                    wall_right,
    input  logic                    wall_top,
    input  logic                    wall_bottom,
    input  logic                    food_here,
    output pix_class_e              pix_class
);

    localparam int unsigned WALL_LO = WALL_W;
    localparam int unsigned WALL_HI = TILE - WALL_W;
    localparam int unsigned FOOD_LO = TILE / 2 - FOOD_W / 2;
    localparam int unsigned FOOD_HI = TILE / 2 + FOOD_W / 2;

    int unsigned x;
    int unsigned y;
    logic        on_wall;
    logic        in_food;

    always_comb begin
        x = 32'(px);
        y = 32'(py);
        on_wall = (x <  WALL_LO && wall_left)  ||
                  (x >= WALL_HI && wall_right) ||
                  (y <  WALL_LO && wall_top)   ||
                  (y >= WALL_HI && wall_bottom);
        in_food = (x >= FOOD_LO) && (x < FOOD_HI) && (y >= FOOD_LO) && (y < FOOD_HI);
        pix_class = PIX_BG;
        if (on_wall)
            pix_class = PIX_WALL;
        else if (food_here && in_food)
            pix_class = PIX_FOOD;
    end

endmodule

// File: rtl/maze_scene_renderer.sv
// Redraws a rectangular tile region on the TFT: address window commands, then pixel bytes.
// Food rendering is compiled in only when MAZE_RENDER_FOOD_EN is defined.
module maze_scene_renderer
    import maze_render_pkg::*;
#(
    parameter int          COLS       = 10,
    parameter int          ROWS       = 15,
    parameter int          TILE       = 32,
    parameter int          WALL_W     = 2,
    parameter int          FOOD_W     = 8,
    parameter int          BPP_BYTES  = 3,
    parameter logic [23:0] WALL_COLOR = DEF_WALL_COLOR,
    parameter logic [23:0] FOOD_COLOR = DEF_FOOD_COLOR,
    parameter logic [23:0] BG_COLOR   = DEF_BG_COLOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(COLS)-1:0]  x0,
    input  logic [$clog2(COLS)-1:0]  x1,
    input  logic [$clog2(ROWS)-1:0]  y0,
    input  logic [$clog2(ROWS)-1:0]  y1,
    input  logic [ROWS*(COLS+1)-1:0] v_walls,
    input  logic [(ROWS+1)*COLS-1:0] h_walls,
    input  logic [ROWS*COLS-1:0]     food,
    input  logic                     tft_busy,
    output logic                     tft_dc,
    output logic [7:0]               tft_data,
    output logic                     tft_transmit,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int PW = $clog2(TILE);
    localparam int VW = $clog2(ROWS * (COLS + 1));
    localparam int HW = $clog2((ROWS + 1) * COLS);

    render_state_e state;
    logic [XW-1:0] xs_t, xe_t, tc;
    logic [YW-1:0] ys_t, ye_t, tr;
    logic [PW-1:0] px, py;
    logic [1:0]    bc, arg_idx;
    logic [15:0]   xs_pix, xe_pix, ys_pix, ye_pix;
    logic [31:0]   arg_word;
    logic [7:0]    arg_byte, pix_byte, cur_byte;
    logic          cur_dc, issuing, can_issue, region_bad;
    logic          last_byte, last_px, last_py, last_col, last_row;
    logic [VW-1:0] v_idx;
    logic [HW-1:0] h_idx;
    logic          food_here;
    pix_class_e    pix_class;
    logic [23:0]   pix_color;

    assign region_bad = (x0 > x1) || (y0 > y1) || (32'(x1) >= COLS) || (32'(y1) >= ROWS);

    assign xs_pix = 16'(int'(xs_t) * TILE);
    assign xe_pix = 16'((int'(xe_t) + 1) * TILE - 1);
    assign ys_pix = 16'(int'(ys_t) * TILE);
    assign ye_pix = 16'((int'(ye_t) + 1) * TILE - 1);

    assign v_idx = VW'(int'(tr) * (COLS + 1) + int'(tc));
    assign h_idx = HW'(int'(tr) * COLS + int'(tc));

`ifdef MAZE_RENDER_FOOD_EN
    localparam int FW = $clog2(ROWS * COLS);
    logic [FW-1:0] f_idx;
    assign f_idx     = FW'(int'(tr) * COLS + int'(tc));
    assign food_here = food[f_idx];
`else
    // Port kept for pin compatibility; its contents never reach the pixel path.
    assign food_here = 1'b0 & (|food);
`endif

    tile_pixel_classifier #(
        .TILE   (TILE),
        .WALL_W (WALL_W),
        .FOOD_W (FOOD_W)
    ) u_classifier (
        .px          (px),
        .py          (py),
        .wall_left   (v_walls[v_idx]),
        .wall_right  (v_walls[v_idx + VW'(1)]),
        .wall_top    (h_walls[h_idx]),
        .wall_bottom (h_walls[h_idx + HW'(COLS)]),
        .food_here   (food_here),
        .pix_class   (pix_class)
    );

    always_comb begin
        case (pix_class)
            PIX_WALL: pix_color = WALL_COLOR;
            PIX_FOOD: pix_color = FOOD_COLOR;
            default:  pix_color = BG_COLOR;
        endcase
        case (bc)
            2'd0:    pix_byte = pix_color[23:16];
            2'd1:    pix_byte = pix_color[15:8];
            default: pix_byte = pix_color[7:0];
        endcase
        arg_word = (state == ST_PASET_ARG) ? {ys_pix, ye_pix} : {xs_pix, xe_pix};
        case (arg_idx)
            2'd0:    arg_byte = arg_word[31:24];
            2'd1:    arg_byte = arg_word[23:16];
            2'd2:    arg_byte = arg_word[15:8];
            default: arg_byte = arg_word[7:0];
        endcase
        cur_dc   = 1'b1;
        cur_byte = '0;
        case (state)
            ST_CASET:                   begin cur_dc = 1'b0; cur_byte = CMD_CASET; end
            ST_PASET:                   begin cur_dc = 1'b0; cur_byte = CMD_PASET; end
            ST_RAMWR:                   begin cur_dc = 1'b0; cur_byte = CMD_RAMWR; end
            ST_CASET_ARG, ST_PASET_ARG: cur_byte = arg_byte;
            ST_PIXELS:                  cur_byte = pix_byte;
            default:                    cur_byte = '0;
        endcase
    end

    assign issuing   = (state != ST_IDLE) && (state != ST_DONE);
    assign can_issue = issuing && !tft_busy && !tft_transmit;
    assign last_byte = (bc == 2'(BPP_BYTES - 1));
    assign last_px   = (px == PW'(TILE - 1));
    assign last_py   = (py == PW'(TILE - 1));
    assign last_col  = (tc == xe_t);
    assign last_row  = (tr == ye_t);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tft_transmit <= 1'b0;
            tft_data     <= '0;
            tft_dc       <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            xs_t <= '0; xe_t <= '0; ys_t <= '0; ye_t <= '0;
            tc <= '0; tr <= '0; px <= '0; py <= '0; bc <= '0; arg_idx <= '0;
        end else begin
            tft_transmit <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            if (can_issue) begin
                tft_data     <= cur_byte;
                tft_dc       <= cur_dc;
                tft_transmit <= 1'b1;
            end
            case (state)
                ST_IDLE: if (start) begin
                    xs_t <= x0; xe_t <= x1; ys_t <= y0; ye_t <= y1;
                    if (region_bad) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else begin
                        busy    <= 1'b1;
                        state   <= ST_CASET;
                        tc      <= x0;
                        tr      <= y0;
                        px      <= '0;
                        py      <= '0;
                        bc      <= '0;
                        arg_idx <= '0;
                    end
                end
                ST_CASET: if (can_issue) state <= ST_CASET_ARG;
                ST_CASET_ARG: if (can_issue) begin
                    arg_idx <= arg_idx + 2'd1;
                    if (arg_idx == 2'd3) state <= ST_PASET;
                end
                ST_PASET: if (can_issue) state <= ST_PASET_ARG;
                ST_PASET_ARG: if (can_issue) begin
                    arg_idx <= arg_idx + 2'd1;
                    if (arg_idx == 2'd3) state <= ST_RAMWR;
                end
                ST_RAMWR: if (can_issue) state <= ST_PIXELS;
                // Wrap chain: byte -> px -> tile column -> py -> tile row.
                ST_PIXELS: if (can_issue) begin
                    if (!last_byte) begin
                        bc <= bc + 2'd1;
                    end else begin
                        bc <= '0;
                        if (!last_px) begin
                            px <= px + PW'(1);
                        end else begin
                            px <= '0;
                            if (!last_col) begin
                                tc <= tc + XW'(1);
                            end else begin
                                tc <= xs_t;
                                if (!last_py) begin
                                    py <= py + PW'(1);
                                end else begin
                                    py <= '0;
                                    if (!last_row) begin
                                        tr <= tr + YW'(1);
                                    end else begin
                                        state <= ST_DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_scene_renderer.sv
// Self-checking bench for maze_scene_renderer against a pixel-coordinate reference model.
module tb_maze_scene_renderer;

    localparam int COLS = 10;
    localparam int ROWS = 15;
    localparam int TILE = 32;
    localparam int WALL_W = 2;
    localparam int FOOD_W = 8;
    localparam int BPP = 3;
    localparam int TILE_BYTES = TILE * TILE * BPP;
    localparam int RUN_LIMIT = 40000;

`ifdef MAZE_RENDER_FOOD_EN
    localparam bit FOOD_EN = 1'b1;
`else
    localparam bit FOOD_EN = 1'b0;
`endif

`define CHECK(TAG, OBS, EXP) \
    begin \
        tests++; \
        assert ((OBS) === (EXP)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

    logic clk = 1'b0;
    logic rst, start, tft_busy;
    logic [3:0] x0, x1, y0, y1;
    logic [ROWS*(COLS+1)-1:0] v_walls;
    logic [(ROWS+1)*COLS-1:0] h_walls;
    logic [ROWS*COLS-1:0] food;
    logic tft_dc, tft_transmit, busy, done, err;
    logic [7:0] tft_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    maze_scene_renderer #(
        .COLS (COLS), .ROWS (ROWS), .TILE (TILE), .WALL_W (WALL_W),
        .FOOD_W (FOOD_W), .BPP_BYTES (BPP)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .x0 (x0), .x1 (x1), .y0 (y0), .y1 (y1),
        .v_walls (v_walls), .h_walls (h_walls), .food (food),
        .tft_busy (tft_busy), .tft_dc (tft_dc), .tft_data (tft_data),
        .tft_transmit (tft_transmit), .busy (busy), .done (done), .err (err)
    );

    // Bus monitor: captured bytes, handshake legality, strobe spacing, done pulses.
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    logic edge_busy, edge_tx;
    int unsigned cyc = 0, last_tx_cyc = 0;
    bit have_last = 0;
    int hs_bad = 0, gap_bad = 0, done_cnt = 0, done_busy = 0, done_err = 0;

    always @(posedge clk) begin
        edge_busy = tft_busy;
        edge_tx   = tft_transmit;
    end

    always @(negedge clk) begin
        cyc++;
        if (tft_transmit) begin
            rx_q.push_back({tft_dc, tft_data});
            if (edge_busy || edge_tx) hs_bad++;
            if (have_last && (cyc - last_tx_cyc) != 2) gap_bad++;
            last_tx_cyc = cyc;
            have_last   = 1'b1;
        end
        if (done) begin
            done_cnt++;
            if (busy) done_busy++;
            if (err) done_err++;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        hs_bad = 0; gap_bad = 0; done_cnt = 0; done_busy = 0; done_err = 0;
        have_last = 1'b0;
    endtask

    function automatic logic [23:0] model_color(int gx, int gy);
        int c  = gx / TILE;
        int r  = gy / TILE;
        int lx = gx % TILE;
        int ly = gy % TILE;
        int lo = TILE / 2 - FOOD_W / 2;
        int hi = TILE / 2 + FOOD_W / 2;
        if ((lx < WALL_W && v_walls[r*(COLS+1)+c]) ||
            (lx >= TILE - WALL_W && v_walls[r*(COLS+1)+c+1]) ||
            (ly < WALL_W && h_walls[r*COLS+c]) ||
            (ly >= TILE - WALL_W && h_walls[(r+1)*COLS+c]))
            return 24'h3A7BD5;
        if (FOOD_EN && food[r*COLS+c] && lx >= lo && lx < hi && ly >= lo && ly < hi)
            return 24'hF0C020;
        return 24'h000000;
    endfunction

    function automatic void push_word(logic [15:0] w);
        exp_q.push_back({1'b1, w[15:8]});
        exp_q.push_back({1'b1, w[7:0]});
    endfunction

    function automatic void build_expected(int a0, int a1, int b0, int b1, int limit);
        logic [23:0] col;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h2A});
        push_word(16'(a0 * TILE));
        push_word(16'((a1 + 1) * TILE - 1));
        exp_q.push_back({1'b0, 8'h2B});
        push_word(16'(b0 * TILE));
        push_word(16'((b1 + 1) * TILE - 1));
        exp_q.push_back({1'b0, 8'h2C});
        for (int gy = b0 * TILE; gy < (b1 + 1) * TILE; gy++) begin
            for (int gx = a0 * TILE; gx < (a1 + 1) * TILE; gx++) begin
                col = model_color(gx, gy);
                for (int b = 0; b < BPP; b++)
                    exp_q.push_back({1'b1, col[23 - 8*b -: 8]});
                if (exp_q.size() >= limit) return;
            end
        end
    endfunction

    task automatic check_stream(input string tag, input int n);
        int bad = 0;
        int first = -1;
        logic [8:0] got = 'x;
        logic [8:0] want = 'x;
        for (int i = 0; i < n; i++) begin
            if (i >= rx_q.size() || i >= exp_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) begin
                    first = i;
                    if (i < rx_q.size()) got = rx_q[i];
                    if (i < exp_q.size()) want = exp_q[i];
                end
            end
        end
        tests++;
        assert (bad === 0) else begin
            fails++;
            $error("FAIL %s: %0d of %0d bytes differ, first at %0d observed %h expected %h",
                   tag, bad, n, first, got, want);
        end
    endtask

    function automatic logic [23:0] pix_at(int px, int py, int ncols);
        int o = 11 + (py * TILE * ncols + px) * BPP;
        if (o + 2 >= rx_q.size()) return 'x;
        return {rx_q[o][7:0], rx_q[o+1][7:0], rx_q[o+2][7:0]};
    endfunction

    task automatic run_region(input int a0, input int a1, input int b0, input int b1,
                              input int stall_pct, input int restart_at);
        bit restarted = 1'b0;
        clear_mon();
        x0 = 4'(a0); x1 = 4'(a1); y0 = 4'(b0); y1 = 4'(b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        `CHECK("busy_after_start", busy, 1'b1)
        for (int i = 0; i < RUN_LIMIT && done_cnt == 0; i++) begin
            start = 1'b0;
            if (restart_at > 0 && !restarted && rx_q.size() == restart_at) begin
                x0 = 4'd0; x1 = 4'd9; y0 = 4'd0; y1 = 4'd14;
                start = 1'b1;
                restarted = 1'b1;
            end
            tft_busy = ($urandom_range(0, 99) < stall_pct);
            @(negedge clk);
        end
        start = 1'b0;
        tft_busy = 1'b0;
        repeat (3) @(negedge clk);
        `CHECK("done_once", done_cnt, 1)
        `CHECK("done_busy_err_clear", done_busy + done_err, 0)
        `CHECK("no_tx_while_busy", hs_bad, 0)
    endtask

    task automatic randomize_maze(input int pct);
        for (int i = 0; i < ROWS*(COLS+1); i++) v_walls[i] = ($urandom_range(0, 99) < pct);
        for (int i = 0; i < (ROWS+1)*COLS; i++) h_walls[i] = ($urandom_range(0, 99) < pct);
        for (int i = 0; i < ROWS*COLS; i++) food[i] = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        int bad_r[4][4] = '{'{5, 4, 0, 0}, '{0, 10, 0, 0}, '{0, 0, 3, 2}, '{0, 0, 0, 15}};
        logic [87:0] pre_got;
        int n_at_rst;
        int ra, rb;

        rst = 1'b1; start = 1'b0; tft_busy = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        v_walls = '0; h_walls = '0; food = '0;
        repeat (3) @(negedge clk);
        `CHECK("reset_ctrl {tx,dc,busy,done,err}", {tft_transmit, tft_dc, busy, done, err}, 5'b01000)
        `CHECK("reset_data", tft_data, 8'h00)
        rst = 1'b0;
        @(negedge clk);

        // Single tile (2,3), empty, no stalls
        build_expected(2, 2, 3, 3, 1 << 30);
        run_region(2, 2, 3, 3, 0, 0);
        pre_got = '0;
        for (int i = 0; i < 11 && i < rx_q.size(); i++) pre_got = {pre_got[79:0], rx_q[i][7:0]};
        `CHECK("single_prefix", pre_got, 88'h2A_00_40_00_5F_2B_00_60_00_7F_2C)
        `CHECK("single_count", rx_q.size(), 11 + TILE_BYTES)
        check_stream("single_stream", exp_q.size());
        `CHECK("single_gap2", gap_bad, 0)

        // Tile (0,0) with left and top walls, stalled transmitter
        v_walls = '0; h_walls = '0; food = '0;
        v_walls[0] = 1'b1; h_walls[0] = 1'b1;
        build_expected(0, 0, 0, 0, 1 << 30);
        run_region(0, 0, 0, 0, 40, 0);
        check_stream("wall_stream", exp_q.size());
        `CHECK("wall_px0_0", pix_at(0, 0, 1), 24'h3A7BD5)
        `CHECK("wall_px1_5", pix_at(1, 5, 1), 24'h3A7BD5)
        `CHECK("wall_px2_2", pix_at(2, 2, 1), 24'h000000)
        `CHECK("wall_px31_31", pix_at(31, 31, 1), 24'h000000)

        // Food in tile (0,0); a second start mid-stream must be ignored
        v_walls = '0; h_walls = '0; food = '0;
        food[0] = 1'b1;
        build_expected(0, 0, 0, 0, 1 << 30);
        run_region(0, 0, 0, 0, 0, 500);
        `CHECK("food_count_after_restart", rx_q.size(), 11 + TILE_BYTES)
        check_stream("food_stream", exp_q.size());
        `CHECK("food_px12_12", pix_at(12, 12, 1), FOOD_EN ? 24'hF0C020 : 24'h000000)
        `CHECK("food_px11_12", pix_at(11, 12, 1), 24'h000000)
        `CHECK("food_px19_19", pix_at(19, 19, 1), FOOD_EN ? 24'hF0C020 : 24'h000000)
        `CHECK("food_px20_12", pix_at(20, 12, 1), 24'h000000)

        // Rejected regions
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            x0 = 4'(bad_r[k][0]); x1 = 4'(bad_r[k][1]);
            y0 = 4'(bad_r[k][2]); y1 = 4'(bad_r[k][3]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            `CHECK("bad_region {done,err,busy}", {done, err, busy}, 3'b110)
            @(negedge clk);
            `CHECK("bad_region_done_cleared", done, 1'b0)
            repeat (10) @(negedge clk);
            `CHECK("bad_region_no_bytes", rx_q.size(), 0)
        end

        // Random maze, two columns wide, stalled
        randomize_maze(35);
        ra = $urandom_range(0, 8);
        rb = $urandom_range(0, 14);
        build_expected(ra, ra + 1, rb, rb, 1 << 30);
        run_region(ra, ra + 1, rb, rb, 30, 0);
        `CHECK("rand_cols_count", rx_q.size(), 11 + 2 * TILE_BYTES)
        check_stream("rand_cols_stream", exp_q.size());

        // Full-screen request aborted by reset during PIXELS
        randomize_maze(35);
        clear_mon();
        build_expected(0, 9, 0, 14, 320);
        x0 = 4'd0; x1 = 4'd9; y0 = 4'd0; y1 = 4'd14;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && rx_q.size() < 300; i++) begin
            tft_busy = ($urandom_range(0, 99) < 30);
            @(negedge clk);
        end
        tft_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        `CHECK("midreset_ctrl {tx,dc,busy,done,err}", {tft_transmit, tft_dc, busy, done, err}, 5'b01000)
        `CHECK("midreset_data", tft_data, 8'h00)
        n_at_rst = rx_q.size();
        check_stream("fullscreen_prefix", 300);
        repeat (40) begin
            tft_busy = ($urandom_range(0, 99) < 30);
            @(negedge clk);
        end
        tft_busy = 1'b0;
        `CHECK("midreset_no_more_bytes", rx_q.size(), n_at_rst)
        `CHECK("midreset_no_done", done_cnt, 0)
        `CHECK("midreset_busy_low", busy, 1'b0)
        `CHECK("midreset_no_tx_while_busy", hs_bad, 0)

        // Recovery: random maze, two rows tall, no stalls
        randomize_maze(35);
        ra = $urandom_range(0, 9);
        rb = $urandom_range(0, 13);
        build_expected(ra, ra, rb, rb + 1, 1 << 30);
        run_region(ra, ra, rb, rb + 1, 0, 0);
        `CHECK("rand_rows_count", rx_q.size(), 11 + 2 * TILE_BYTES)
        check_stream("rand_rows_stream", exp_q.size());
        `CHECK("rand_rows_gap2", gap_bad, 0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maze_scene_renderer.md
Name: maze_scene_renderer

Overview:
Parametrised maze scene renderer. Redraws any rectangular region of tiles on the TFT, not only the full screen.
- Issues the address-window commands itself: CASET 0x2A, PASET 0x2B, RAMWR 0x2C.
- Then streams pixel bytes classified as wall, food or background.
- Sits between the game logic (wall/food bitmaps, dirty-region requests) and the byte-level TFT transmitter. Runs only after tft_init has finished.

Parameters:
- COLS, 10, tiles per row.
- ROWS, 15, tiles per column.
- TILE, 32, tile edge in pixels; power of two, 4..64.
- WALL_W, 2, wall thickness in pixels measured inward from the tile edge.
- FOOD_W, 8, edge of the centred food square in pixels; even.
- BPP_BYTES, 3, bytes per pixel, 1..3.
- WALL_COLOR, 24'h3A7BD5, wall colour.
- FOOD_COLOR, 24'hF0C020, food colour.
- BG_COLOR, 24'h000000, background colour.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse
- x0, x1  in  $clog2(COLS) each  inclusive tile column range
- y0, y1  in  $clog2(ROWS) each  inclusive tile row range
- v_walls  in  ROWS*(COLS+1)  bit r*(COLS+1)+c = wall on left edge of tile (r,c)
- h_walls  in  (ROWS+1)*COLS  bit r*COLS+c = wall on top edge of tile (r,c)
- food  in  ROWS*COLS  bit r*COLS+c = food in tile (r,c)
- tft_busy  in  1  transmitter busy
- tft_dc  out  1  0 = command byte, 1 = data byte
- tft_data  out  8  byte to send
- tft_transmit  out  1  one-cycle send strobe
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; request rejected

Behaviour:
- Reset values: tft_transmit=0, tft_data=0, tft_dc=1, busy=0, done=0, err=0. State is IDLE.
- Reset mid-operation aborts immediately: no done pulse, no further bytes.
- Region capture:
  - start in IDLE latches x0..y1; start while busy is ignored.
  - If x0>x1, y0>y1, x1>=COLS or y1>=ROWS, the next cycle gives done=1, err=1, no bytes sent.
  - Otherwise busy=1 from the cycle after start until the cycle done pulses.
  - Walls and food are sampled live; the caller holds them stable while busy.
- Byte handshake: a byte is issued only in a cycle where tft_busy=0 and tft_transmit=0. That cycle drives tft_data/tft_dc and sets tft_transmit=1; the next cycle clears it. Peak rate is one byte per 2 cycles; tft_data/tft_dc hold until the next issue.
- State sequence: IDLE -> CASET -> CASET_ARG(4) -> PASET -> PASET_ARG(4) -> RAMWR -> PIXELS -> DONE -> IDLE.
  - Command bytes use dc=0; arguments and pixels use dc=1.
  - CASET args: xs=x0*TILE, xe=(x1+1)*TILE-1, each 16-bit big-endian (xs_hi, xs_lo, xe_hi, xe_lo).
  - PASET args: same form with y.
- Pixel order: raster within the window, pixel x innermost then y. Each pixel sends BPP_BYTES bytes, MSB first, taken from colour bits [23:24-8*BPP_BYTES].
  - Total pixel bytes = (x1-x0+1)*(y1-y0+1)*TILE*TILE*BPP_BYTES.
- Pixel classification, with local offsets px,py in 0..TILE-1 inside tile (r,c):
  - Wall if any of: px<WALL_W and left wall; px>=TILE-WALL_W and left wall of tile c+1; py<WALL_W and top wall; py>=TILE-WALL_W and top wall of row r+1.
  - Otherwise food if the food bit is set and both px,py are in [TILE/2-FOOD_W/2, TILE/2+FOOD_W/2).
  - Otherwise background. Wall has priority over food.
- Outer border bits (c=COLS, r=ROWS) are read from the vectors as given; they are not forced.
- Counters: pixel-in-tile counters of width $clog2(TILE), tile counters, byte-in-pixel counter. Wrap order: byte -> px -> tile col (back to x0) -> py -> tile row. The last byte of the last pixel moves to DONE.
- DONE: done=1 for one cycle, err=0, busy=0 in that same cycle.

Optional Feature:
Macro MAZE_RENDER_FOOD_EN.
- Defined: food classification as above.
- Undefined: the food port is ignored and non-wall pixels are BG_COLOR; all other behaviour and byte counts are identical.

Decomposition:
- Package maze_render_pkg holds: opcode constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C; the state enumeration; default colour constants.
- Sub-module tile_pixel_classifier (combinational): inputs px, py and the four edge bits plus the food bit; output a 2-bit class (BG/WALL/FOOD). It is shared by this block and future sprite overlays.

Test Plan:
- Single tile (2,3)-(2,3), no walls, no food, TILE=32, BPP=3, tft_busy held 0 -> bytes 2A,00,40,00,5F,2B,00,60,00,7F,2C, then 3072 bytes of 00; done once; bytes 2 cycles apart.
- Full screen 0..9 x 0..14, all walls clear -> 11 prefix bytes, 460800 pixel bytes, done=1, err=0.
- Tile (0,0) with left and top walls, WALL_W=2 -> pixel(0,0) sends 3A,7B,D5; pixel(2,2) sends 00,00,00; pixel(31,31) is background.
- Food in tile (0,0), no walls, MAZE_RENDER_FOOD_EN defined -> pixel(12,12) sends F0,C0,20 and pixel(11,12) is BG. With the macro undefined, both are BG.
- Request x0=5, x1=4 -> done and err on the next cycle, zero tft_transmit pulses. A second start while busy leaves the byte count unchanged.
- Random tft_busy stalls plus rst asserted mid-PIXELS -> no transmit while tft_busy=1; after rst all outputs are at reset values, busy=0, no done pulse.
